mmio_led_timer: RTL and testbench
=================================

Name: mmio_led_timer

Overview:
Memory-mapped peripheral on the core's data-memory port, in parallel with the registered data RAM inside the board wrapper. It decodes a small word-addressed register window and drives the 8 board LEDs with static and blink patterns. It also provides a free-running cycle counter readable by software. Reads are registered, giving one-cycle latency identical to the data RAM, so the wrapper muxes ddata_r using hit_q.

Parameters:
ADDR_SIZE, 10, width of daddr (word address)
DATA_SIZE, 32, data bus width (must be 32)
BASE_ADDR, 10'h3F8, window base; must be 8-word aligned
PERIOD_W, 24, width of blink period register/counter

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
CLEAR  in  1  synchronous clear, same effect as reset
daddr  in  ADDR_SIZE  data word address from core
ddata_w  in  DATA_SIZE  write data
mem_write  in  1  write strobe
mem_read  in  1  read strobe
ddata_r  out  DATA_SIZE  registered read data
hit_q  out  1  registered "last access hit this window"; wrapper selects ddata_r over RAM
LED  out  8  board LEDs, active high

Behaviour:
- Decode: hit = daddr[ADDR_SIZE-1:3] == BASE_ADDR[ADDR_SIZE-1:3]; offset = daddr[2:0].
- Registers (offset): 0 LED_OUT[7:0] RW; 1 BLINK_MASK[7:0] RW; 2 BLINK_PERIOD[PERIOD_W-1:0] RW; 3 CYCLE_COUNT[31:0] RO; 4 STATUS RO/W1C: bit0 blink phase (RO), bit1 counter-overflow sticky (W1C); 5–7 reserved, read 0, writes ignored. Unused upper bits read 0.
- Write: hit & mem_write, on the rising edge; takes effect next cycle.
- Read: hit & mem_read samples the register at the edge; ddata_r valid the following cycle (1-cycle latency). hit_q = registered (hit & mem_read). When hit_q=0, ddata_r = 0.
- Simultaneous read and write to the same offset: write committed; ddata_r returns the pre-write value.
- CYCLE_COUNT: +1 every cycle; wraps 0xFFFFFFFF→0 and sets STATUS[1] on that cycle. If a W1C to bit1 coincides with a wrap, set wins.
- Blink: counter bc counts 0..BLINK_PERIOD-1; on reaching BLINK_PERIOD-1 it goes to 0 and phase toggles. BLINK_PERIOD=0: bc held 0, phase held 0. Any write to BLINK_PERIOD clears bc and phase next cycle.
- LED = LED_OUT ^ (BLINK_MASK & {8{phase}}), registered (one cycle after state change).
- Reset/CLEAR (any time, including mid-access): all registers, counters, phase, STATUS, ddata_r, hit_q, LED = 0. A read in flight when CLEAR asserts is dropped (hit_q=0 next cycle).
- Accesses outside the window: no state change, hit_q=0.

Optional Feature:
MMIO_LED_PWM_EN: defined — offset 5 is PWM_DUTY[7:0] RW (reset 0xFF); free-running 8-bit pwm_cnt; LED = pattern & {8{pwm_cnt < PWM_DUTY}}, except duty 0xFF forces continuous on. Undefined — offset 5 reserved (reads 0), no pwm_cnt, LED ungated.

Test Plan:
- Reset: hold RESET_N=0 mid-run, release -> LED=0, ddata_r=0, hit_q=0, CYCLE_COUNT read immediately returns a small value (<4).
- Write 0xA5 to offset 0 (daddr=0x3F8), read back -> LED=0xA5 one cycle after write; ddata_r=0x000000A5 with hit_q=1 exactly one cycle after read strobe.
- LED_OUT=0x00, BLINK_MASK=0x0F, BLINK_PERIOD=4 -> LED alternates 0x00/0x0F every 4 cycles; STATUS[0] follows phase; writing period 0 freezes LED at 0x00.
- Read of address 0x3F0 (RAM region) and of offset 6 -> hit_q=0, ddata_r=0 for the former; hit_q=1, ddata_r=0 for the latter; no register changes.
- Same-cycle read+write to offset 1 (old 0x11, new 0x22) -> ddata_r=0x11, subsequent read 0x22.
- Force CYCLE_COUNT to 0xFFFFFFFE (hierarchical deposit) -> wraps to 0 two cycles later, STATUS=0x2; write 0x2 to offset 4 -> STATUS bit1 cleared; W1C on the wrap cycle -> bit1 stays 1.

Source files
------------

// File: rtl/mmio_led_timer.sv
// Memory-mapped LED/timer peripheral: static + blink LED patterns, free-running cycle counter.
// Optional macro MMIO_LED_PWM_EN adds PWM_DUTY at offset 5 and gates the LEDs with an 8-bit PWM.
module mmio_led_timer #(
    parameter int                   ADDR_SIZE = 10,
    parameter int                   DATA_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 10'h3F8,
    parameter int                   PERIOD_W  = 24
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CLEAR,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic [DATA_SIZE-1:0] ddata_w,
    input  logic                 mem_write,
    input  logic                 mem_read,
    output logic [DATA_SIZE-1:0] ddata_r,
    output logic                 hit_q,
    output logic [7:0]           LED
);

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = 1;

    logic                 hit;
    logic [2:0]           offset;
    logic                 wr;
    logic                 rd;
    logic [DATA_SIZE-1:0] rdata;
    logic [7:0]           pattern;
    logic [7:0]           led_out;
    logic [7:0]           blink_mask;
    logic [PERIOD_W-1:0]  blink_period;
    logic [PERIOD_W-1:0]  bc;
    logic                 phase;
    logic [31:0]          cycle_count;
    logic                 ovf;
    logic                 unused_bits;

    assign hit         = (daddr[ADDR_SIZE-1:3] == BASE_ADDR[ADDR_SIZE-1:3]);
    assign offset      = daddr[2:0];
    assign wr          = hit & mem_write;
    assign rd          = hit & mem_read;
    assign unused_bits = ^ddata_w[DATA_SIZE-1:PERIOD_W];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_out      <= '0;
            blink_mask   <= '0;
            blink_period <= '0;
        end else if (CLEAR) begin
            led_out      <= '0;
            blink_mask   <= '0;
            blink_period <= '0;
        end else if (wr) begin
            if (offset == 3'd0) led_out      <= ddata_w[7:0];
            if (offset == 3'd1) blink_mask   <= ddata_w[7:0];
            if (offset == 3'd2) blink_period <= ddata_w[PERIOD_W-1:0];
        end
    end

    // Overflow set takes priority over a coincident W1C.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_count <= '0;
            ovf         <= 1'b0;
        end else if (CLEAR) begin
            cycle_count <= '0;
            ovf         <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (cycle_count == 32'hFFFF_FFFF)
                ovf <= 1'b1;
            else if (wr && offset == 3'd4 && ddata_w[1])
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bc    <= '0;
            phase <= 1'b0;
        end else if (CLEAR) begin
            bc    <= '0;
            phase <= 1'b0;
        end else if ((wr && offset == 3'd2) || blink_period == '0) begin
            bc    <= '0;
            phase <= 1'b0;
        end else if (bc == blink_period - PERIOD_ONE) begin
            bc    <= '0;
            phase <= ~phase;
        end else begin
            bc    <= bc + PERIOD_ONE;
        end
    end

    assign pattern = led_out ^ (blink_mask & {8{phase}});

`ifdef MMIO_LED_PWM_EN
    logic [7:0] pwm_duty;
    logic [7:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_duty == 8'hFF) || (pwm_cnt < pwm_duty);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_duty <= 8'hFF;
            pwm_cnt  <= '0;
            LED      <= '0;
        end else if (CLEAR) begin
            pwm_duty <= 8'hFF;
            pwm_cnt  <= '0;
            LED      <= '0;
        end else begin
            if (wr && offset == 3'd5) pwm_duty <= ddata_w[7:0];
            pwm_cnt <= pwm_cnt + 8'd1;
            LED     <= pattern & {8{pwm_on}};
        end
    end
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)   LED <= '0;
        else if (CLEAR) LED <= '0;
        else            LED <= pattern;
    end
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            3'd0: rdata[7:0]          = led_out;
            3'd1: rdata[7:0]          = blink_mask;
            3'd2: rdata[PERIOD_W-1:0] = blink_period;
            3'd3: rdata[31:0]         = cycle_count;
            3'd4: rdata[1:0]          = {ovf, phase};
`ifdef MMIO_LED_PWM_EN
            3'd5: rdata[7:0]          = pwm_duty;
`endif
            default: rdata = '0;
        endcase
    end

    // Read data is captured before any same-edge write lands, so RMW returns the old value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_q   <= 1'b0;
            ddata_r <= '0;
        end else if (CLEAR) begin
            hit_q   <= 1'b0;
            ddata_r <= '0;
        end else begin
            hit_q   <= rd;
            ddata_r <= rd ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_mmio_led_timer.sv
// Directed self-checking bench for mmio_led_timer; inputs driven and outputs sampled on negedge.
module tb_mmio_led_timer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CLEAR;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] ddata_r;
    logic        hit_q;
    logic [7:0]  LED;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] BASE = 10'h3F8;

    mmio_led_timer dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .daddr(daddr), .ddata_w(ddata_w),
        .mem_write(mem_write), .mem_read(mem_read), .ddata_r(ddata_r), .hit_q(hit_q), .LED(LED)
    );

    always #5 CLK = ~CLK;

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
        daddr = addr; ddata_w = data; mem_write = 1'b1;
        @(negedge CLK);
        mem_write = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] addr, output logic [31:0] d, output logic h);
        daddr = addr; mem_read = 1'b1;
        @(negedge CLK);
        mem_read = 1'b0;
        d = ddata_r; h = hit_q;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic h;
        do_write(BASE + 10'd0, 32'h3C);
        @(negedge CLK);
        checks++; if (LED !== 8'h3C) begin errors++; $display("FAIL pre_reset_led: got %h want %h", LED, 8'h3C); end
        RESET_N = 1'b0;
        #1;
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL async_reset_led: got %h want %h", LED, 8'h00); end
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want %h", LED, 8'h00); end
        checks++; if (ddata_r !== 32'h0) begin errors++; $display("FAIL reset_ddata_r: got %h want %h", ddata_r, 32'h0); end
        checks++; if (hit_q !== 1'b0) begin errors++; $display("FAIL reset_hit_q: got %b want %b", hit_q, 1'b0); end
        do_read(BASE + 10'd3, d, h);
        checks++; if (!(h === 1'b1 && d < 32'd4)) begin errors++; $display("FAIL reset_cycle_count: got %h hit %b want <4 hit 1", d, h); end
        do_read(BASE + 10'd0, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_led_out: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_led_rw();
        logic [31:0] d; logic h;
        do_write(BASE + 10'd0, 32'hA5);
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL led_early: got %h want %h", LED, 8'h00); end
        @(negedge CLK);
        checks++; if (LED !== 8'hA5) begin errors++; $display("FAIL led_after_write: got %h want %h", LED, 8'hA5); end
        do_read(BASE + 10'd0, d, h);
        checks++; if (d !== 32'h0000_00A5 || h !== 1'b1) begin errors++; $display("FAIL led_readback: got %h hit %b want %h hit 1", d, h, 32'hA5); end
        @(negedge CLK);
        checks++; if (ddata_r !== 32'h0 || hit_q !== 1'b0) begin errors++; $display("FAIL idle_after_read: got %h hit %b want 0 hit 0", ddata_r, hit_q); end
    endtask

    task automatic test_blink();
        logic [31:0] d; logic h; logic [7:0] exp_led;
        do_write(BASE + 10'd0, 32'h00);
        do_write(BASE + 10'd1, 32'h0F);
        do_write(BASE + 10'd2, 32'd4);
        daddr = BASE + 10'd4; mem_read = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            exp_led = ((((k - 1) / 4) % 2) == 1) ? 8'h0F : 8'h00;
            checks++; if (LED !== exp_led) begin errors++; $display("FAIL blink_led[%0d]: got %h want %h", k, LED, exp_led); end
            checks++; if (ddata_r !== {31'b0, exp_led[0]} || hit_q !== 1'b1) begin errors++; $display("FAIL blink_status[%0d]: got %h hit %b want %h", k, ddata_r, hit_q, {31'b0, exp_led[0]}); end
        end
        mem_read = 1'b0;
        do_write(BASE + 10'd2, 32'd0);
        @(negedge CLK);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            checks++; if (LED !== 8'h00) begin errors++; $display("FAIL blink_frozen[%0d]: got %h want %h", k, LED, 8'h00); end
        end
        do_read(BASE + 10'd4, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL frozen_status: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_window();
        logic [31:0] d; logic h; logic [31:0] exp5;
        do_write(10'h3F0, 32'hFF);
        do_read(10'h3F0, d, h);
        checks++; if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL ram_region_read: got %h hit %b want 0 hit 0", d, h); end
        do_write(BASE + 10'd6, 32'hFFFF_FFFF);
        do_read(BASE + 10'd6, d, h);
        checks++; if (h !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reserved6_read: got %h hit %b want 0 hit 1", d, h); end
        do_read(BASE + 10'd7, d, h);
        checks++; if (h !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reserved7_read: got %h hit %b want 0 hit 1", d, h); end
`ifdef MMIO_LED_PWM_EN
        exp5 = 32'hFF;
`else
        exp5 = 32'h0;
`endif
        do_read(BASE + 10'd5, d, h);
        checks++; if (h !== 1'b1 || d !== exp5) begin errors++; $display("FAIL offset5_read: got %h hit %b want %h", d, h, exp5); end
        do_read(BASE + 10'd0, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL window_led_out: got %h want %h", d, 32'h0); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL window_led: got %h want %h", LED, 8'h00); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; logic h;
        do_write(BASE + 10'd1, 32'h11);
        daddr = BASE + 10'd1; ddata_w = 32'h22; mem_read = 1'b1; mem_write = 1'b1;
        @(negedge CLK);
        mem_read = 1'b0; mem_write = 1'b0;
        checks++; if (ddata_r !== 32'h11 || hit_q !== 1'b1) begin errors++; $display("FAIL rw_old_value: got %h hit %b want %h", ddata_r, hit_q, 32'h11); end
        do_read(BASE + 10'd1, d, h);
        checks++; if (d !== 32'h22) begin errors++; $display("FAIL rw_new_value: got %h want %h", d, 32'h22); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic h;
        dut.cycle_count = 32'hFFFF_FFFE;
        do_read(BASE + 10'd3, d, h);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL count_deposit: got %h want %h", d, 32'hFFFF_FFFE); end
        do_read(BASE + 10'd3, d, h);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_max: got %h want %h", d, 32'hFFFF_FFFF); end
        do_read(BASE + 10'd4, d, h);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_status: got %h want %h", d, 32'h2); end
        do_read(BASE + 10'd3, d, h);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL count_wrapped: got %h want %h", d, 32'h1); end
        do_write(BASE + 10'd4, 32'h1);
        do_read(BASE + 10'd4, d, h);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_bit0_only: got %h want %h", d, 32'h2); end
        do_write(BASE + 10'd4, 32'h2);
        do_read(BASE + 10'd4, d, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want %h", d, 32'h0); end
        dut.cycle_count = 32'hFFFF_FFFE;
        @(negedge CLK);
        do_write(BASE + 10'd4, 32'h2);
        do_read(BASE + 10'd4, d, h);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_on_wrap: got %h want %h", d, 32'h2); end
        do_write(BASE + 10'd4, 32'h2);
    endtask

    task automatic test_clear();
        logic [31:0] d; logic h;
        do_write(BASE + 10'd0, 32'h5A);
        @(negedge CLK);
        checks++; if (LED !== 8'h5A) begin errors++; $display("FAIL pre_clear_led: got %h want %h", LED, 8'h5A); end
        daddr = BASE + 10'd0; mem_read = 1'b1; CLEAR = 1'b1;
        @(negedge CLK);
        mem_read = 1'b0; CLEAR = 1'b0;
        checks++; if (hit_q !== 1'b0 || ddata_r !== 32'h0) begin errors++; $display("FAIL clear_drops_read: got %h hit %b want 0 hit 0", ddata_r, hit_q); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL clear_led: got %h want %h", LED, 8'h00); end
        do_read(BASE + 10'd0, d, h);
        checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL clear_led_out: got %h hit %b want 0 hit 1", d, h); end
        do_read(BASE + 10'd3, d, h);
        checks++; if (d >= 32'd4) begin errors++; $display("FAIL clear_count: got %h want <4", d); end
    endtask

    initial begin
        RESET_N = 1'b0; CLEAR = 1'b0; daddr = '0; ddata_w = '0; mem_write = 1'b0; mem_read = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        test_reset();
        test_led_rw();
        test_blink();
        test_window();
        test_same_cycle();
        test_overflow();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
